datapath_unit: RTL and testbench
================================

Name: datapath_unit

Overview:
Accumulator-machine datapath that sits directly downstream of the instruction controller. It consumes the controller's strobes (LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU) and holds all architectural state: PC, IR, 16-entry register file, accumulator and Z/C flags. It feeds Opcode, Z and C back to the controller and drives the instruction-memory address.

Parameters:
PC_W, 8, program counter / instruction address width
DATA_W, 8, accumulator, register, IR and instruction-memory data width (Opcode width equals DATA_W)

Ports:
CLK  input  1  clock, rising edge
CLB  input  1  asynchronous active-low reset
LoadIR  input  1  capture ImemData into IR
IncPC  input  1  PC <= PC+1
SelPC  input  1  jump target select: 0 = register R[IR[3:0]], 1 = ImemData
LoadPC  input  1  load PC with selected target
LoadReg  input  1  R[IR[3:0]] <= Acc
LoadAcc  input  1  Acc <= SelAcc mux output
SelAcc  input  2  00 hold, 01 zero-extended IR[3:0], 10 ALU result, 11 ImemData
SelALU  input  4  ALU operation
ImemData  input  DATA_W  instruction-memory read data (combinational from ImemAddr)
ImemAddr  output  PC_W  = PC
Opcode  output  DATA_W  = IR
Z  output  1  zero flag (registered)
C  output  1  carry/borrow flag (registered)
AccOut  output  DATA_W  = Acc, for debug/IO

Behaviour:
- Reset (CLB low, asynchronous, any time incl. mid-instruction): PC=0, IR=0, Acc=0, all 16 registers=0, Z=0, C=0. Outputs reflect these immediately; first rising edge after CLB deasserts performs normal updates.
- All state updates on rising CLK; all strobes sampled on the same edge; all sources use pre-edge values (no forwarding).
- PC: LoadPC=1 -> PC <= target (SelPC=0: R[IR[3:0]] truncated/zero-extended to PC_W; SelPC=1: ImemData likewise). Else IncPC=1 -> PC <= PC+1, wrapping 2^PC_W-1 -> 0. LoadPC has priority over IncPC. Neither -> hold.
- IR: LoadIR=1 -> IR <= ImemData; else hold. LoadIR with IncPC in same cycle: IR gets data at old PC, PC advances.
- Register file: 16 x DATA_W, index IR[3:0] (pre-edge IR). LoadReg=1 -> R[idx] <= Acc (pre-edge Acc). LoadReg and LoadAcc together: register receives old Acc.
- ALU (combinational): A = Acc, B = R[IR[3:0]].
  0000 PASS B (C=0); 0001 PASS A (C=0); 0010 ADD A+B, C = carry-out; 0011 SUB A-B, C = borrow (1 when A<B unsigned); 0100 NOR ~(A|B) (C=0); 0101 AND (C=0); all other codes -> PASS A, C=0.
  Result truncated to DATA_W.
- Acc: LoadAcc=1 -> Acc <= mux(SelAcc); SelAcc=00 holds. LoadAcc=0 -> hold regardless of SelAcc.
- Flags: updated only on an edge with LoadAcc=1 and SelAcc=10. Z <= (ALU result==0), C <= ALU carry/borrow. All other cycles: hold. Flags never change on LoadReg, LoadPC or SelAcc 01/11 loads.
- No internal FSM stalls; every strobe completes in one cycle. Opcode, Z, C and AccOut are valid the cycle after the causing edge.

Test Plan:
- Reset: drive strobes random, assert CLB low mid-run -> PC=0, IR=0, Acc=0, Z=0, C=0 immediately; R[0..15] read back 0 via PASS B.
- Fetch/wrap: PC=8'hFF, LoadIR=1, IncPC=1, ImemData=8'h23 -> IR=8'h23, PC=8'h00.
- ADD carry: Acc=8'hF0, R[3]=8'h10, IR=8'h13, SelALU=0010, SelAcc=10, LoadAcc=1 -> Acc=8'h00, Z=1, C=1.
- SUB borrow then MOVR: Acc=8'h05, R[3]=8'h07, SUB -> Acc=8'hFE, Z=0, C=1; then SelALU=0000 with LoadAcc -> Acc=R[3]=8'h07, Z=0, C=0.
- LoadReg/LoadAcc collision: Acc=8'h5A, IR low nibble=4, LoadReg=1, LoadAcc=1, SelAcc=01 -> R[4]=8'h5A, Acc=8'h04, Z/C unchanged.
- Jump priority: R[2]=8'h40, IR=8'h62, LoadPC=1, IncPC=1, SelPC=0 -> PC=8'h40; repeat with SelPC=1, ImemData=8'h99 -> PC=8'h99.

Source files
------------

// File: rtl/datapath_unit.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_unit
//  Description : Accumulator-machine datapath. Holds PC, IR, a 16-entry
//                register file, the accumulator and Z/C flags, and executes
//                the single-cycle strobes issued by the instruction
//                controller.
//  Ports       : CLK       - clock, rising edge
//                CLB       - asynchronous active-low reset
//                LoadIR    - IR <= ImemData
//                IncPC     - PC <= PC + 1 (wraps)
//                SelPC     - jump source: 0 = R[IR[3:0]], 1 = ImemData
//                LoadPC    - PC <= jump target (priority over IncPC)
//                LoadReg   - R[IR[3:0]] <= Acc
//                LoadAcc   - Acc <= SelAcc mux output
//                SelAcc    - 00 hold, 01 IR[3:0], 10 ALU, 11 ImemData
//                SelALU    - ALU operation
//                ImemData  - instruction-memory read data
//                ImemAddr  - instruction-memory address (= PC)
//                Opcode    - current instruction (= IR)
//                Z, C      - registered zero / carry-borrow flags
//                AccOut    - accumulator value
//  Revision    : 1.0 - initial release
// ============================================================================
module datapath_unit #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              CLB,
  input  logic              LoadIR,
  input  logic              IncPC,
  input  logic              SelPC,
  input  logic              LoadPC,
  input  logic              LoadReg,
  input  logic              LoadAcc,
  input  logic [1:0]        SelAcc,
  input  logic [3:0]        SelALU,
  input  logic [DATA_W-1:0] ImemData,
  output logic [PC_W-1:0]   ImemAddr,
  output logic [DATA_W-1:0] Opcode,
  output logic              Z,
  output logic              C,
  output logic [DATA_W-1:0] AccOut
);

  localparam logic [3:0] c_ALU_PASS_B = 4'b0000;
  localparam logic [3:0] c_ALU_PASS_A = 4'b0001;
  localparam logic [3:0] c_ALU_ADD    = 4'b0010;
  localparam logic [3:0] c_ALU_SUB    = 4'b0011;
  localparam logic [3:0] c_ALU_NOR    = 4'b0100;
  localparam logic [3:0] c_ALU_AND    = 4'b0101;

  localparam logic [1:0] c_ACC_HOLD = 2'b00;
  localparam logic [1:0] c_ACC_IMM  = 2'b01;
  localparam logic [1:0] c_ACC_ALU  = 2'b10;
  localparam logic [1:0] c_ACC_MEM  = 2'b11;

  localparam logic [PC_W-1:0] c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  // Architectural state
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_acc;
  logic              r_z;
  logic              r_c;
  logic [DATA_W-1:0] r_regs [16];

  // Combinational datapath
  logic [3:0]        w_idx;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W:0]   w_alu_sum;
  logic [DATA_W:0]   w_alu_dif;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_c;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_acc_nxt;
  logic [DATA_W-1:0] w_tgt_src;
  logic [PC_W-1:0]   w_tgt;
  logic              w_flag_upd;

  assign w_idx     = r_ir[3:0];
  assign w_b       = r_regs[w_idx];

  // One extra bit captures carry-out on ADD and borrow on SUB.
  assign w_alu_sum = {1'b0, r_acc} + {1'b0, w_b};
  assign w_alu_dif = {1'b0, r_acc} - {1'b0, w_b};

  always_comb begin
    w_alu_res = r_acc;
    w_alu_c   = 1'b0;
    case (SelALU)
      c_ALU_PASS_B: w_alu_res = w_b;
      c_ALU_PASS_A: w_alu_res = r_acc;
      c_ALU_ADD: begin
        w_alu_res = w_alu_sum[DATA_W-1:0];
        w_alu_c   = w_alu_sum[DATA_W];
      end
      c_ALU_SUB: begin
        w_alu_res = w_alu_dif[DATA_W-1:0];
        w_alu_c   = w_alu_dif[DATA_W];
      end
      c_ALU_NOR:    w_alu_res = ~(r_acc | w_b);
      c_ALU_AND:    w_alu_res = r_acc & w_b;
      default:      w_alu_res = r_acc;
    endcase
  end

  always_comb begin
    w_imm      = '0;
    w_imm[3:0] = r_ir[3:0];
  end

  always_comb begin
    w_acc_nxt = r_acc;
    case (SelAcc)
      c_ACC_HOLD: w_acc_nxt = r_acc;
      c_ACC_IMM:  w_acc_nxt = w_imm;
      c_ACC_ALU:  w_acc_nxt = w_alu_res;
      c_ACC_MEM:  w_acc_nxt = ImemData;
      default:    w_acc_nxt = r_acc;
    endcase
  end

  // Flags track only ALU results actually written to the accumulator.
  assign w_flag_upd = LoadAcc && (SelAcc == c_ACC_ALU);

  // Jump target: register or memory byte, fitted to the PC width.
  assign w_tgt_src = SelPC ? ImemData : w_b;

  generate
    if (PC_W <= DATA_W) begin : g_tgt_trunc
      assign w_tgt = w_tgt_src[PC_W-1:0];
    end else begin : g_tgt_zext
      assign w_tgt = {{(PC_W-DATA_W){1'b0}}, w_tgt_src};
    end
  endgenerate

  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      r_pc <= '0;
    end else if (LoadPC) begin
      r_pc <= w_tgt;
    end else if (IncPC) begin
      r_pc <= r_pc + c_PC_ONE;
    end
  end

  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      r_ir <= '0;
    end else if (LoadIR) begin
      r_ir <= ImemData;
    end
  end

  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      r_acc <= '0;
    end else if (LoadAcc) begin
      r_acc <= w_acc_nxt;
    end
  end

  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      r_z <= 1'b0;
      r_c <= 1'b0;
    end else if (w_flag_upd) begin
      r_z <= (w_alu_res == '0);
      r_c <= w_alu_c;
    end
  end

  // Register write uses pre-edge Acc, so a same-cycle Acc load is not seen.
  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= '0;
      end
    end else if (LoadReg) begin
      r_regs[w_idx] <= r_acc;
    end
  end

  assign ImemAddr = r_pc;
  assign Opcode   = r_ir;
  assign Z        = r_z;
  assign C        = r_c;
  assign AccOut   = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_datapath_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datapath_unit
//  Description : Self-checking bench for datapath_unit. Directed scenarios
//                plus random strobe sequences compared each cycle against
//                an architectural model of the machine.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_unit;

  logic       CLK;
  logic       CLB;
  logic       LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0] SelAcc;
  logic [3:0] SelALU;
  logic [7:0] ImemData;
  logic [7:0] ImemAddr;
  logic [7:0] Opcode;
  logic       Z, C;
  logic [7:0] AccOut;

  datapath_unit #(.PC_W(8), .DATA_W(8)) dut (
    .CLK      (CLK),
    .CLB      (CLB),
    .LoadIR   (LoadIR),
    .IncPC    (IncPC),
    .SelPC    (SelPC),
    .LoadPC   (LoadPC),
    .LoadReg  (LoadReg),
    .LoadAcc  (LoadAcc),
    .SelAcc   (SelAcc),
    .SelALU   (SelALU),
    .ImemData (ImemData),
    .ImemAddr (ImemAddr),
    .Opcode   (Opcode),
    .Z        (Z),
    .C        (C),
    .AccOut   (AccOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  // Architectural model
  int m_pc, m_ir, m_acc, m_z, m_c;
  int m_r [16];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_pc"},  {8'h00, ImemAddr}, 16'(m_pc));
    chk({tag, "_ir"},  {8'h00, Opcode},   16'(m_ir));
    chk({tag, "_acc"}, {8'h00, AccOut},   16'(m_acc));
    chk({tag, "_z"},   {15'h0, Z},        16'(m_z));
    chk({tag, "_c"},   {15'h0, C},        16'(m_c));
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_acc = 0; m_z = 0; m_c = 0;
    for (int i = 0; i < 16; i++) m_r[i] = 0;
  endtask

  // Apply one cycle of strobes, advance the model, clock, then check.
  task automatic step(input logic lir, input logic inc, input logic spc,
                      input logic lpc, input logic lreg, input logic lacc,
                      input logic [1:0] sa, input logic [3:0] alu,
                      input logic [7:0] im, input string tag);
    int b, res, cy, n_pc, n_ir, n_acc, n_z, n_c;
    LoadIR = lir; IncPC = inc; SelPC = spc; LoadPC = lpc;
    LoadReg = lreg; LoadAcc = lacc; SelAcc = sa; SelALU = alu; ImemData = im;

    b  = m_r[m_ir % 16];
    cy = 0;
    case (alu)
      4'd0: res = b;
      4'd2: begin res = (m_acc + b) % 256; cy = (m_acc + b > 255) ? 1 : 0; end
      4'd3: begin res = (m_acc - b + 256) % 256; cy = (m_acc < b) ? 1 : 0; end
      4'd4: res = 255 - (m_acc | b);
      4'd5: res = m_acc & b;
      default: res = m_acc;
    endcase

    n_pc = m_pc; n_ir = m_ir; n_acc = m_acc; n_z = m_z; n_c = m_c;
    if (lpc)      n_pc = spc ? int'(im) : b;
    else if (inc) n_pc = (m_pc + 1) % 256;
    if (lir) n_ir = im;
    if (lacc) begin
      case (sa)
        2'd1: n_acc = m_ir % 16;
        2'd2: begin n_acc = res; n_z = (res == 0) ? 1 : 0; n_c = cy; end
        2'd3: n_acc = im;
        default: n_acc = m_acc;
      endcase
    end
    if (lreg) m_r[m_ir % 16] = m_acc;
    m_pc = n_pc; m_ir = n_ir; m_acc = n_acc; m_z = n_z; m_c = n_c;

    @(posedge CLK);
    #1;
    chk_all(tag);
  endtask

  task automatic set_ir(input logic [7:0] v);
    step(1, 0, 0, 0, 0, 0, 2'd0, 4'd0, v, "set_ir");
  endtask
  task automatic set_acc(input logic [7:0] v);
    step(0, 0, 0, 0, 0, 1, 2'd3, 4'd0, v, "set_acc");
  endtask
  task automatic set_pc(input logic [7:0] v);
    step(0, 0, 1, 1, 0, 0, 2'd0, 4'd0, v, "set_pc");
  endtask
  task automatic write_reg(input logic [3:0] idx, input logic [7:0] v);
    set_ir({4'h0, idx});
    set_acc(v);
    step(0, 0, 0, 0, 1, 0, 2'd0, 4'd0, 8'h00, "wr_reg");
  endtask
  task automatic alu_op(input logic [3:0] op, input string tag);
    step(0, 0, 0, 0, 0, 1, 2'd2, op, $urandom_range(0, 255), tag);
  endtask

  // Assert reset asynchronously between edges with random strobes applied.
  task automatic async_reset();
    LoadIR = 1'($urandom); IncPC = 1'($urandom); SelPC = 1'($urandom);
    LoadPC = 1'($urandom); LoadReg = 1'($urandom); LoadAcc = 1'($urandom);
    SelAcc = 2'($urandom); SelALU = 4'($urandom); ImemData = 8'($urandom);
    #2 CLB = 1'b0;
    #1;
    model_reset();
    chk_all("rst_imm");
    @(posedge CLK);
    #1;
    chk_all("rst_hold");
    CLB = 1'b1;
  endtask

  initial begin
    CLB = 1'b0;
    LoadIR = 0; IncPC = 0; SelPC = 0; LoadPC = 0; LoadReg = 0; LoadAcc = 0;
    SelAcc = 2'd0; SelALU = 4'd0; ImemData = 8'h00;
    model_reset();
    #1;
    chk_all("por");
    @(posedge CLK);
    #1;
    CLB = 1'b1;

    // Dirty the machine, then reset mid-run and read every register back.
    for (int i = 0; i < 20; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 2'($urandom), 4'($urandom), 8'($urandom), "pre_rst");
    end
    async_reset();
    for (int k = 0; k < 16; k++) begin
      set_ir(8'(k));
      alu_op(4'd0, "rst_rd");
      chk("rst_reg_zero", {8'h00, AccOut}, 16'h0000);
    end

    // Fetch with PC wrap
    set_pc(8'hFF);
    step(1, 1, 0, 0, 0, 0, 2'd0, 4'd0, 8'h23, "fetch_wrap");
    chk("wrap_ir", {8'h00, Opcode}, 16'h0023);
    chk("wrap_pc", {8'h00, ImemAddr}, 16'h0000);

    // ADD with carry-out to zero
    write_reg(4'd3, 8'h10);
    set_acc(8'hF0);
    set_ir(8'h13);
    alu_op(4'd2, "add");
    chk("add_acc", {8'h00, AccOut}, 16'h0000);
    chk("add_z", {15'h0, Z}, 16'h0001);
    chk("add_c", {15'h0, C}, 16'h0001);

    // Register write and accumulator load in the same cycle; flags stay 1/1
    set_ir(8'h04);
    set_acc(8'h5A);
    step(0, 0, 0, 0, 1, 1, 2'd1, 4'd0, 8'h00, "collide");
    chk("coll_acc", {8'h00, AccOut}, 16'h0004);
    chk("coll_z", {15'h0, Z}, 16'h0001);
    chk("coll_c", {15'h0, C}, 16'h0001);
    alu_op(4'd0, "coll_rd");
    chk("coll_r4", {8'h00, AccOut}, 16'h005A);

    // SUB with borrow, then PASS B
    set_ir(8'h03);
    set_acc(8'h07);
    step(0, 0, 0, 0, 1, 0, 2'd0, 4'd0, 8'h00, "wr_r3");
    set_acc(8'h05);
    alu_op(4'd3, "sub");
    chk("sub_acc", {8'h00, AccOut}, 16'h00FE);
    chk("sub_z", {15'h0, Z}, 16'h0000);
    chk("sub_c", {15'h0, C}, 16'h0001);
    alu_op(4'd0, "movr");
    chk("movr_acc", {8'h00, AccOut}, 16'h0007);
    chk("movr_c", {15'h0, C}, 16'h0000);

    // Jump priority over increment, both target sources
    write_reg(4'd2, 8'h40);
    set_ir(8'h62);
    step(0, 1, 0, 1, 0, 0, 2'd0, 4'd0, 8'h00, "jmp_reg");
    chk("jmp_reg_pc", {8'h00, ImemAddr}, 16'h0040);
    step(0, 1, 1, 1, 0, 0, 2'd0, 4'd0, 8'h99, "jmp_mem");
    chk("jmp_mem_pc", {8'h00, ImemAddr}, 16'h0099);

    // Random strobe sequences with one reset dropped in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom),
           8'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
